// File: rtl/i2s_dac_tx.sv
// I2S master transmitter: serialises stereo PCM pairs onto bclk/daclrck/dacdat, one pair per frame.
// One-entry pending buffer; in_ready is low while it is full and rises after the frame load drains it.
module i2s_dac_tx #(
   parameter int WIDTH     = 16,
   parameter int SLOT_BITS = 32,
   parameter int BCLK_HALF = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_left,
   input  logic [WIDTH-1:0] in_right,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             bclk,
   output logic             daclrck,
   output logic             dacdat,
   output logic             frame_start,
   output logic             underrun
);
   localparam int DIV_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
   localparam int BIT_W = $clog2(2 * SLOT_BITS);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF - 1);
   localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_BITS - 1);
   localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
   localparam logic [BIT_W-1:0] SLOT_C   = BIT_W'(SLOT_BITS);
   localparam logic [BIT_W-1:0] WIDTH_C  = BIT_W'(WIDTH);

   logic [DIV_W-1:0] divcnt_q, divcnt_d;
   logic             bclk_q, bclk_d;
   logic [BIT_W-1:0] bitcnt_q, bitcnt_d;
   logic             daclrck_q, daclrck_d;
   logic             dacdat_q, dacdat_d;
   logic [WIDTH-1:0] left_sh_q, left_sh_d;
   logic [WIDTH-1:0] right_sh_q, right_sh_d;
   logic [WIDTH-1:0] pend_left_q, pend_left_d;
   logic [WIDTH-1:0] pend_right_q, pend_right_d;
   logic             pend_full_q, pend_full_d;
   logic             in_ready_q, in_ready_d;
   logic             frame_start_q, frame_start_d;
   logic             underrun_q, underrun_d;

   logic             toggle;
   logic             fall;
   logic             accept;
   logic             right_slot;
   logic [BIT_W-1:0] bit_next;
   logic [BIT_W-1:0] pos;

   always_ff @(posedge clk) begin
      if (reset) begin
         divcnt_q      <= '0;
         bclk_q        <= 1'b0;
         bitcnt_q      <= BIT_LAST;
         daclrck_q     <= 1'b0;
         dacdat_q      <= 1'b0;
         left_sh_q     <= '0;
         right_sh_q    <= '0;
         pend_left_q   <= '0;
         pend_right_q  <= '0;
         pend_full_q   <= 1'b0;
         in_ready_q    <= 1'b1;
         frame_start_q <= 1'b0;
         underrun_q    <= 1'b0;
      end else begin
         divcnt_q      <= divcnt_d;
         bclk_q        <= bclk_d;
         bitcnt_q      <= bitcnt_d;
         daclrck_q     <= daclrck_d;
         dacdat_q      <= dacdat_d;
         left_sh_q     <= left_sh_d;
         right_sh_q    <= right_sh_d;
         pend_left_q   <= pend_left_d;
         pend_right_q  <= pend_right_d;
         pend_full_q   <= pend_full_d;
         in_ready_q    <= in_ready_d;
         frame_start_q <= frame_start_d;
         underrun_q    <= underrun_d;
      end
   end

   always_comb begin
      divcnt_d      = divcnt_q + DIV_ONE;
      bclk_d        = bclk_q;
      bitcnt_d      = bitcnt_q;
      daclrck_d     = daclrck_q;
      dacdat_d      = dacdat_q;
      left_sh_d     = left_sh_q;
      right_sh_d    = right_sh_q;
      pend_left_d   = pend_left_q;
      pend_right_d  = pend_right_q;
      pend_full_d   = pend_full_q;
      frame_start_d = 1'b0;
      underrun_d    = 1'b0;

      toggle     = (divcnt_q == DIV_LAST);
      fall       = toggle && bclk_q;
      accept     = in_valid && in_ready_q;
      bit_next   = (bitcnt_q == BIT_LAST) ? '0 : bitcnt_q + BIT_ONE;
      right_slot = (bit_next >= SLOT_C);
      pos        = right_slot ? (bit_next - SLOT_C) : bit_next;

      if (toggle) begin
         divcnt_d = '0;
         bclk_d   = ~bclk_q;
      end

      // All serial state moves on the falling bclk edge so dacdat is settled for the codec's rising-edge sample.
      if (fall) begin
         bitcnt_d  = bit_next;
         daclrck_d = right_slot;
         dacdat_d  = 1'b0;
         if (bit_next == '0) begin
            frame_start_d = 1'b1;
            if (pend_full_q) begin
               left_sh_d   = pend_left_q;
               right_sh_d  = pend_right_q;
               pend_full_d = 1'b0;
            end else begin
               left_sh_d  = '0;
               right_sh_d = '0;
               underrun_d = 1'b1;
            end
         end else if ((pos != '0) && (pos <= WIDTH_C)) begin
            if (right_slot) begin
               dacdat_d   = right_sh_q[WIDTH-1];
               right_sh_d = right_sh_q << 1;
            end else begin
               dacdat_d  = left_sh_q[WIDTH-1];
               left_sh_d = left_sh_q << 1;
            end
         end
      end

      // An accept coinciding with an empty-buffer load lands after the load has already taken zeros.
      if (accept) begin
         pend_left_d  = in_left;
         pend_right_d = in_right;
         pend_full_d  = 1'b1;
      end

      in_ready_d = ~pend_full_d;
   end

   assign in_ready    = in_ready_q;
   assign bclk        = bclk_q;
   assign daclrck     = daclrck_q;
   assign dacdat      = dacdat_q;
   assign frame_start = frame_start_q;
   assign underrun    = underrun_q;

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Bench for i2s_dac_tx: frame-table stimulus, expected-frame scoreboard, deserialising monitor.
// Second instance exercises a non-default parameter set.
module tb_i2s_dac_tx;
   localparam int FRAME = 1024;
   localparam int A_NONE = 0;
   localparam int A_SEND = 1;
   localparam int A_AT_LOAD = 2;

   logic        clk;
   logic        reset;
   logic [15:0] in_left, in_right;
   logic        in_valid, in_ready;
   logic        bclk, daclrck, dacdat, frame_start, underrun;

   logic        reset_p;
   logic [19:0] in_left_p, in_right_p;
   logic        in_valid_p, in_ready_p;
   logic        bclk_p, daclrck_p, dacdat_p, frame_start_p, underrun_p;

   i2s_dac_tx u_dut (
      .clk(clk), .reset(reset), .in_left(in_left), .in_right(in_right),
      .in_valid(in_valid), .in_ready(in_ready), .bclk(bclk), .daclrck(daclrck),
      .dacdat(dacdat), .frame_start(frame_start), .underrun(underrun)
   );

   i2s_dac_tx #(.WIDTH(20), .SLOT_BITS(24), .BCLK_HALF(2)) u_dut_p (
      .clk(clk), .reset(reset_p), .in_left(in_left_p), .in_right(in_right_p),
      .in_valid(in_valid_p), .in_ready(in_ready_p), .bclk(bclk_p), .daclrck(daclrck_p),
      .dacdat(dacdat_p), .frame_start(frame_start_p), .underrun(underrun_p)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] l;
      logic [15:0] r;
      logic        ur;
   } exp_t;

   typedef struct {
      int          act;
      logic [15:0] l;
      logic [15:0] r;
      logic [15:0] el;
      logic [15:0] er;
      logic        eur;
   } row_t;

   exp_t        sb[$];
   row_t        tbl[7];
   int          checks;
   int          errors;
   int          cyc;
   int          next_load;
   int          nrise;
   logic        in_frame;
   logic        bclk_prev;
   logic [15:0] cur_l, cur_r;
   logic [63:0] got_dat, got_lr;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h at cycle %0d", name, got, exp, cyc);
      end
   endtask

   function automatic logic [63:0] frame_bits(input logic [15:0] l, input logic [15:0] r);
      logic [63:0] f;
      f = '0;
      for (int i = 0; i < 16; i++) begin
         f[62 - i] = l[15 - i];
         f[30 - i] = r[15 - i];
      end
      return f;
   endfunction

   // Advance one clk edge, then sample the default-parameter DUT and score frames.
   task automatic tick();
      exp_t e;
      @(posedge clk);
      #2;
      cyc++;
      if (reset) begin
         next_load = cyc + 16;
         in_frame  = 1'b0;
      end else begin
         chk("underrun_alone", {63'd0, underrun & ~frame_start}, 64'd0);
         if (frame_start) begin
            chk("load_cycle", cyc, next_load);
            next_load += FRAME;
            chk("sb_has_entry", {63'd0, sb.size() != 0}, 64'd1);
            e = '0;
            e.ur = 1'b1;
            if (sb.size() != 0) e = sb.pop_front();
            chk("underrun_flag", {63'd0, underrun}, {63'd0, e.ur});
            cur_l    = e.l;
            cur_r    = e.r;
            in_frame = 1'b1;
            nrise    = 0;
            got_dat  = '0;
            got_lr   = '0;
         end else if (cyc == next_load) begin
            chk("load_missing", {63'd0, frame_start}, 64'd1);
            next_load += FRAME;
         end
         if (in_frame && bclk && !bclk_prev) begin
            got_dat[63 - nrise] = dacdat;
            got_lr[63 - nrise]  = daclrck;
            nrise++;
            if (nrise == 64) begin
               chk("frame_dat", got_dat, frame_bits(cur_l, cur_r));
               chk("frame_lrck", got_lr, 64'h00000000FFFFFFFF);
               in_frame = 1'b0;
            end
         end
      end
      bclk_prev = bclk;
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) tick();
   endtask

   task automatic send(input logic [15:0] l, input logic [15:0] r, output int waited, output int acc_cyc);
      waited  = 0;
      acc_cyc = -1;
      while (!in_ready && waited < 1100) begin
         tick();
         waited++;
      end
      chk("send_ready", {63'd0, in_ready}, 64'd1);
      if (waited > 0) chk("ready_with_load", {63'd0, frame_start}, 64'd1);
      if (in_ready) begin
         in_left  = l;
         in_right = r;
         in_valid = 1'b1;
         acc_cyc  = cyc + 1;
         tick();
         in_valid = 1'b0;
         chk("ready_drop", {63'd0, in_ready}, 64'd0);
      end
   endtask

   initial begin
      int rel, load_k, w, acc, rst_cyc, relp, fs1, fs2, nr;
      logic prev;
      logic [47:0] got48, lr48, exp48;
      exp_t e;

      tbl[0] = '{A_NONE,    16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1};
      tbl[1] = '{A_NONE,    16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1};
      tbl[2] = '{A_SEND,    16'hA5C3, 16'h0F0F, 16'hA5C3, 16'h0F0F, 1'b0};
      tbl[3] = '{A_NONE,    16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1};
      tbl[4] = '{A_AT_LOAD, 16'h1234, 16'h5678, 16'h0000, 16'h0000, 1'b1};
      tbl[5] = '{A_NONE,    16'h0000, 16'h0000, 16'h1234, 16'h5678, 1'b0};
      tbl[6] = '{A_NONE,    16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1};

      checks = 0; errors = 0; cyc = 0; next_load = 0; nrise = 0;
      in_frame = 1'b0; bclk_prev = 1'b0; cur_l = '0; cur_r = '0;
      got_dat = '0; got_lr = '0;
      reset = 1'b1; in_left = '0; in_right = '0; in_valid = 1'b0;
      reset_p = 1'b1; in_left_p = '0; in_right_p = '0; in_valid_p = 1'b0;

      repeat (4) tick();
      chk("rst_bclk", {63'd0, bclk}, 64'd0);
      chk("rst_daclrck", {63'd0, daclrck}, 64'd0);
      chk("rst_dacdat", {63'd0, dacdat}, 64'd0);
      chk("rst_frame_start", {63'd0, frame_start}, 64'd0);
      chk("rst_underrun", {63'd0, underrun}, 64'd0);
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

      reset = 1'b0;
      rel = cyc;

      for (int k = 0; k < 7; k++) begin
         load_k = rel + 16 + FRAME * k;
         e.l = tbl[k].el; e.r = tbl[k].er; e.ur = tbl[k].eur;
         sb.push_back(e);
         if (tbl[k].act == A_SEND) begin
            send(tbl[k].l, tbl[k].r, w, acc);
            chk("send_immediate", w, 0);
         end else if (tbl[k].act == A_AT_LOAD) begin
            wait_until(load_k - 1);
            chk("ready_before_load", {63'd0, in_ready}, 64'd1);
            in_left = tbl[k].l; in_right = tbl[k].r; in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            chk("load_with_accept", {63'd0, frame_start}, 64'd1);
            chk("ready_after_accept", {63'd0, in_ready}, 64'd0);
         end
         wait_until(load_k + 1017);
      end

      // Backpressure: three pairs offered back to back across frames 7..9.
      load_k = rel + 16 + FRAME * 7;
      for (int v = 1; v <= 3; v++) begin
         e.l = 16'(v); e.r = 16'(v << 8); e.ur = 1'b0;
         sb.push_back(e);
      end
      e = '0; e.ur = 1'b1;
      sb.push_back(e);
      send(16'h0001, 16'h0100, w, acc);
      chk("bp_first_immediate", w, 0);
      send(16'h0002, 16'h0200, w, acc);
      chk("bp_second_accept", acc, load_k + 1);
      send(16'h0003, 16'h0300, w, acc);
      chk("bp_third_accept", acc, load_k + FRAME + 1);
      wait_until(rel + 16 + FRAME * 10 + 1017);

      // Reset in the right slot while a pair is pending: pair must be dropped.
      load_k = rel + 16 + FRAME * 11;
      e = '0; e.ur = 1'b1;
      sb.push_back(e);
      wait_until(load_k + 20);
      send(16'hBEEF, 16'hCAFE, w, acc);
      wait_until(load_k + 700);
      chk("mid_right_lrck", {63'd0, daclrck}, 64'd1);
      chk("mid_pending_full", {63'd0, in_ready}, 64'd0);
      reset = 1'b1;
      tick();
      rst_cyc = cyc;
      chk("mrst_bclk", {63'd0, bclk}, 64'd0);
      chk("mrst_daclrck", {63'd0, daclrck}, 64'd0);
      chk("mrst_dacdat", {63'd0, dacdat}, 64'd0);
      chk("mrst_in_ready", {63'd0, in_ready}, 64'd1);
      chk("mrst_frame_start", {63'd0, frame_start}, 64'd0);
      reset = 1'b0;
      e = '0; e.ur = 1'b1;
      sb.push_back(e);
      wait_until(rst_cyc + 16 + 1017);
      chk("sb_drained", sb.size(), 0);

      // Alternate parameter set on the second instance.
      reset = 1'b1;
      tick();
      reset_p = 1'b0;
      relp = cyc;
      chk("p_ready", {63'd0, in_ready_p}, 64'd1);
      in_left_p = 20'h80001; in_right_p = 20'h40002; in_valid_p = 1'b1;
      tick();
      in_valid_p = 1'b0;
      fs1 = -1; fs2 = -1; nr = 0; prev = 1'b0; got48 = '0; lr48 = '0;
      for (int i = 0; i < 400 && fs2 < 0; i++) begin
         tick();
         if (frame_start_p) begin
            if (fs1 < 0) begin
               fs1 = cyc;
               chk("p_no_underrun", {63'd0, underrun_p}, 64'd0);
            end else begin
               fs2 = cyc;
            end
         end
         if (fs1 >= 0 && fs2 < 0 && bclk_p && !prev && nr < 48) begin
            got48[47 - nr] = dacdat_p;
            lr48[47 - nr]  = daclrck_p;
            nr++;
         end
         prev = bclk_p;
      end
      exp48 = '0;
      exp48[47 - 1]  = 1'b1;
      exp48[47 - 20] = 1'b1;
      exp48[47 - 26] = 1'b1;
      exp48[47 - 43] = 1'b1;
      chk("p_first_load", fs1, relp + 4);
      chk("p_frame_period", fs2 - fs1, 192);
      chk("p_frame_dat", {16'd0, got48}, {16'd0, exp48});
      chk("p_frame_lrck", {16'd0, lr48}, 64'h0000_0000_00FF_FFFF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
